// File: rtl/flag_div_ctrl.sv
// Run-time controller for the flag-based even clock divider.
// A period counter emits a one-cycle cnt_flag; IDLE/RUN/STOP sequencing handles bursts and graceful stop.
module flag_div_ctrl #(
  parameter int DIV_W       = 8,
  parameter int BURST_W     = 8,
  parameter int DIV_DEFAULT = 6
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               cnt_flag,
  output logic               done,
  output logic               busy,
  output logic [BURST_W-1:0] flag_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0]   DIV_TWO   = DIV_W'(2);
  localparam logic [DIV_W-1:0]   DIV_RST   = DIV_W'(DIV_DEFAULT);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] flag_cnt_q, flag_cnt_d;
  logic               cnt_flag_q, cnt_flag_d;
  logic               done_q, done_d;

  logic               wrap;
  logic [BURST_W-1:0] flag_nxt;
  logic               burst_hit;

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign cnt_flag  = cnt_flag_q;
  assign done      = done_q;
  assign flag_cnt  = flag_cnt_q;

  assign wrap      = (cnt_q == div_q - DIV_ONE);
  assign flag_nxt  = flag_cnt_q + BURST_ONE;
  assign burst_hit = (burst_q != '0) && (flag_nxt == burst_q);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    flag_cnt_d = flag_cnt_q;
    cnt_flag_d = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          // Ratios below 2 cannot produce a one-of-D flag; clamp them.
          div_d   = (cfg_div < DIV_TWO) ? DIV_TWO : cfg_div;
          burst_d = cfg_burst;
        end
        if (start) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          flag_cnt_d = '0;
        end
      end
      S_RUN, S_STOP: begin
        cnt_d = wrap ? '0 : cnt_q + DIV_ONE;
        if (wrap) begin
          cnt_flag_d = 1'b1;
          flag_cnt_d = flag_nxt;
        end
        // A flag in STOP is always final; a burst-final flag beats a same-edge stop.
        if (wrap && (state_q == S_STOP || burst_hit)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (state_q == S_RUN && stop) begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      div_q      <= DIV_RST;
      burst_q    <= '0;
      cnt_q      <= '0;
      flag_cnt_q <= '0;
      cnt_flag_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      flag_cnt_q <= flag_cnt_d;
      cnt_flag_q <= cnt_flag_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_flag_div_ctrl.sv
// Bench for flag_div_ctrl: directed steps plus random traffic against a run/elapsed-time model.
module tb_flag_div_ctrl;

  logic       sys_clk, sys_rst;
  logic       cfg_valid, cfg_ready;
  logic [7:0] cfg_div, cfg_burst;
  logic       start, stop;
  logic       cnt_flag, done, busy;
  logic [7:0] flag_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a run is "busy" with an elapsed-cycle count; flags fall on multiples of D.
  bit m_busy, m_stopping, m_flag, m_done;
  int m_elapsed, m_div, m_burst, m_flags;

  flag_div_ctrl #(.DIV_W(8), .BURST_W(8), .DIV_DEFAULT(6)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_burst(cfg_burst),
    .start(start), .stop(stop),
    .cnt_flag(cnt_flag), .done(done), .busy(busy), .flag_cnt(flag_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_stopping = 0; m_flag = 0; m_done = 0;
    m_elapsed = 0; m_div = 6; m_burst = 0; m_flags = 0;
  endtask

  task automatic model_edge();
    m_flag = 0;
    m_done = 0;
    if (!m_busy) begin
      if (cfg_valid) begin
        m_div   = (cfg_div < 2) ? 2 : int'(cfg_div);
        m_burst = int'(cfg_burst);
      end
      if (start) begin
        m_busy = 1; m_stopping = 0; m_elapsed = 0; m_flags = 0;
      end
    end else begin
      m_elapsed++;
      m_flag = (m_elapsed % m_div) == 0;
      if (m_flag) m_flags++;
      if (m_flag && (m_stopping || (m_burst != 0 && (m_flags % 256) == m_burst))) begin
        m_done = 1;
        m_busy = 0;
      end else if (stop) begin
        m_stopping = 1;
      end
    end
  endtask

  task automatic check_all();
    check("cnt_flag", cnt_flag, m_flag);
    check("done", done, m_done);
    check("busy", busy, m_busy);
    check("cfg_ready", cfg_ready, !m_busy);
    check("flag_cnt", flag_cnt, m_flags % 256);
  endtask

  task automatic cyc(input bit v, input int d, input int b, input bit st, input bit sp);
    cfg_valid = v; cfg_div = 8'(d); cfg_burst = 8'(b); start = st; stop = sp;
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear without a clock.
  task automatic do_reset();
    sys_rst = 1'b1;
    #1;
    check("rst_cnt_flag", cnt_flag, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_flag_cnt", flag_cnt, 0);
    model_reset();
    #1 sys_rst = 1'b0;
  endtask

  initial begin
    cfg_valid = 0; cfg_div = 0; cfg_burst = 0; start = 0; stop = 0;
    sys_rst = 0;
    model_reset();
    do_reset();

    // Default ratio 6, continuous; then graceful stop.
    cyc(0, 0, 0, 1, 0);
    idle(19);
    cyc(0, 0, 0, 0, 1);
    idle(8);

    // Burst of 3 at D=4.
    cyc(1, 4, 3, 0, 0);
    cyc(0, 0, 0, 1, 0);
    idle(18);

    // Ratio 1 clamps to 2; config offered mid-run is held off.
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    idle(4);
    repeat (4) cyc(1, 9, 0, 0, 0);
    idle(4);
    cyc(0, 0, 0, 0, 1);
    idle(4);

    // D=6: stop at cnt=2, then stop on a flag edge.
    cyc(1, 6, 0, 1, 0);
    idle(2);
    cyc(0, 0, 0, 0, 1);
    idle(8);
    cyc(0, 0, 0, 1, 0);
    idle(5);
    cyc(0, 0, 0, 0, 1);
    idle(14);

    // Config and start on the same edge; then stop on the first flag of a 2-burst.
    cyc(1, 3, 2, 1, 0);
    idle(8);
    cyc(0, 0, 0, 1, 0);
    idle(2);
    cyc(0, 0, 0, 0, 1);
    idle(6);

    // start+stop in IDLE, back-to-back restarts with burst 1 at D=2.
    cyc(1, 2, 1, 1, 1);
    repeat (6) cyc(0, 0, 0, 1, 0);
    idle(3);

    // Reset mid-period at D=10, then the default ratio must return.
    cyc(1, 10, 0, 1, 0);
    idle(4);
    do_reset();
    cyc(0, 0, 0, 1, 0);
    idle(14);
    cyc(0, 0, 0, 0, 1);
    idle(8);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 4) == 0), int'($urandom_range(0, 9)), int'($urandom_range(0, 5)),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flag_div_ctrl.md
# flag_div_ctrl

Run-time controller for the team's flag-based even clock divider. It owns a period counter and a one-cycle `cnt_flag` output, and accepts a divide ratio and burst length through a valid/ready configuration port. It sequences the divider through IDLE/RUN/STOP under `start`/`stop` commands and reports completion. It sits between a control master (button logic, register file or a higher-level scheduler) and any logic clocked-enabled by the divided flag.

## Interface
- `DIV_W`, default 8: width of divide ratio.
- `BURST_W`, default 8: width of burst length and flag counter.
- `DIV_DEFAULT`, default 6: divide ratio after reset; must be ≥2.

Ports:
- `sys_clk`  in  1  single system clock; all logic on rising edge.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration accepted this cycle if `cfg_valid`; high only in IDLE.
- `cfg_div`  in  DIV_W  divide ratio.
- `cfg_burst`  in  BURST_W  number of flags per run; 0 = continuous.
- `start`  in  1  begin run (level sampled, acted on in IDLE only).
- `stop`  in  1  graceful stop request (acted on in RUN only).
- `cnt_flag`  out  1  one-cycle pulse at the end of each period (registered).
- `done`  out  1  one-cycle pulse, coincident with the final flag of a run.
- `busy`  out  1  state ≠ IDLE.
- `flag_cnt`  out  BURST_W  flags emitted since last accepted start.

## Operation
- Registers: `div_reg` (reset `DIV_DEFAULT`), `burst_reg` (reset 0), `cnt` (DIV_W, reset 0), `flag_cnt` (reset 0), state (reset IDLE). `cnt_flag`/`done` reset 0.
- Config handshake:
  - Accept when `cfg_valid && cfg_ready`; `cfg_ready` is combinational `state==IDLE`.
  - `cfg_div` of 0 or 1 is stored as 2.
  - While not IDLE, `cfg_valid` is held off with no side effect.
- FSM:
  - IDLE: `start` → RUN. `cnt` ← 0 and `flag_cnt` ← 0. If a config is accepted on the same edge, the run uses the new values.
  - RUN: `cnt` counts 0..`div_reg`−1 and wraps. On the edge where `cnt==div_reg−1`, `cnt_flag` ← 1 (else 0) and `flag_cnt` ← `flag_cnt`+1, wrapping modulo 2^BURST_W.
    - If `burst_reg≠0` and this flag brings `flag_cnt` to `burst_reg`: `done` ← 1 on the same edge and state → IDLE.
    - `stop` sampled in RUN (not at a burst-final edge) → STOP. The counter keeps running.
  - STOP: at the next period end, emit the flag, pulse `done` and go → IDLE. If `stop` is sampled on the same edge a flag is emitted, that flag is not final; the next period end is.
- Simultaneous events:
  - `start`+`stop` in IDLE: start wins.
  - `stop` on a burst-final edge: burst completion wins, single `done`.
  - `start` while busy: ignored.
  - `stop` in STOP: no effect.
- Reset mid-run: all registers return to reset values immediately (asynchronously), including `div_reg`. `cnt_flag`/`done` drop without completing the pulse.

## Timing
- Start sampled at edge E0: `busy` high after E0. `cnt_flag` is high for the cycle following edges E0+D, E0+2D, … (D = `div_reg`).
- `done` and final `cnt_flag` are high in the same cycle. `busy` is already low in that cycle, and `cfg_ready` is high in it.
- Minimum restart: `start` sampled on the edge ending the `done` cycle begins a new run with no gap cycle.
- Flag duty: 1 of D cycles; period exactly D cycles in continuous mode, no jitter across wrap.
- Config latency: values are usable by a run starting on the accepting edge.

## Test plan
- Reset, no config, `start` at E0 → `cnt_flag` after E6, E12, E18; `busy`=1, `cfg_ready`=0; `flag_cnt`=3 after E18.
- Config `cfg_div`=4, `cfg_burst`=3, then start at E0 → flags after E4, E8, E12. `done` is high with the third flag, `busy`=0 in that cycle, and no flag after E16.
- `cfg_div`=1, burst 0 → stored as 2; flags every 2 cycles. `cfg_valid` asserted during RUN with `cfg_div`=9 → `cfg_ready`=0 and period stays 2.
- D=6 continuous; `stop` pulsed when `cnt`=2 → one more flag 4 cycles later with `done`, then IDLE and no further flags. Repeat with `stop` on a flag edge → the flag at the next period end is the final one, and `done` is high with it.
- Config accepted and `start` on the same edge (D=3, burst=2) → flags after E3, E6 with `done`. D=3, burst=2, `stop` on the edge of flag 1 → final flag after E6 with a single `done`.
- `sys_rst` asserted mid-period in RUN with D=10 → outputs 0 immediately, `div_reg` back to 6. The next start gives a period of 6.
